// File: rtl/mux_8x1_rr_arbiter.sv
// ============================================================================
// Module      : mux_8x1_rr_arbiter
// Description : Round-robin owner scheduler for an 8:1 one-bit channel with
//               bounded burst tenure and a registered channel output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_8x1_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] in,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       out,
    output logic       out_valid
);

    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] count_q, count_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic       out_q, out_d;
    logic       out_valid_q, out_valid_d;

    logic       w_release;
    logic [2:0] w_ptr_next;
    logic [3:0] w_pick_idle;
    logic [3:0] w_pick_rearb;

    // Returns {found, index}; scanning downward lets the lowest offset from p win.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign busy         = |grant_q;
    assign w_release    = !req[sel_q] || (count_q == c_max_burst);
    assign w_ptr_next   = sel_q + 3'd1;
    assign w_pick_idle  = rr_pick(req, ptr_q);
    assign w_pick_rearb = rr_pick(req, w_ptr_next);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        grant_d = grant_q;
        sel_d   = sel_q;

        case (state_q)
            ST_IDLE: begin
                if (w_pick_idle[3]) begin
                    grant_d = 8'd1 << w_pick_idle[2:0];
                    sel_d   = w_pick_idle[2:0];
                    count_d = 4'd1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    // Handover happens on the release edge itself, no idle bubble.
                    ptr_d = w_ptr_next;
                    if (w_pick_rearb[3]) begin
                        grant_d = 8'd1 << w_pick_rearb[2:0];
                        sel_d   = w_pick_rearb[2:0];
                        count_d = 4'd1;
                    end else begin
                        grant_d = 8'd0;
                        count_d = 4'd0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        out_d       = busy ? in[sel_q] : 1'b0;
        out_valid_d = busy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            count_q     <= 4'd0;
            grant_q     <= 8'd0;
            sel_q       <= 3'd0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_8x1_rr_arbiter.sv
// ============================================================================
// Module      : tb_mux_8x1_rr_arbiter
// Description : Directed scoreboard bench for the 8-way round-robin channel
//               scheduler with MAX_BURST = 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_8x1_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] in_v;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       out;
    logic       out_valid;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] g;
        logic [2:0] s;
        logic       o;
        logic       ov;
        string      name;
    } exp_t;

    exp_t sb[$];

    mux_8x1_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in        (in_v),
        .grant     (grant),
        .sel       (sel),
        .busy      (busy),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Monitor: compares the entry due for the edge just taken.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk({e.name, "_stale"}, 32'(cyc), 32'(e.cyc));
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk({e.name, "_grant"}, 32'(grant), 32'(e.g));
            chk({e.name, "_sel"}, 32'(sel), 32'(e.s));
            chk({e.name, "_busy"}, 32'(busy), 32'(|e.g));
            chk({e.name, "_out"}, 32'(out), 32'(e.o));
            chk({e.name, "_out_valid"}, 32'(out_valid), 32'(e.ov));
            chk({e.name, "_onehot0"}, 32'($onehot0(grant)), 32'd1);
        end
    end

    // Drive inputs for the next edge and queue the state expected after it.
    task automatic step(input string nm, input logic [7:0] r, input logic [7:0] d,
                        input logic [7:0] eg, input logic [2:0] es,
                        input logic eo, input logic eov);
        exp_t e;
        req  = r;
        in_v = d;
        e.cyc = cyc + 1; e.g = eg; e.s = es; e.o = eo; e.ov = eov; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        in_v = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h00);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;

        // Single holder: requester 3 keeps the channel across burst boundaries.
        for (int i = 0; i < 12; i++)
            step("hold", 8'h08, 8'h08, 8'h08, 3'd3, i != 0, i != 0);
        step("hold_drop", 8'h00, 8'h08, 8'h00, 3'd3, 1'b1, 1'b1);
        step("hold_idle", 8'h00, 8'h08, 8'h00, 3'd3, 1'b0, 1'b0);

        // Pointer is now 4, so requester 4 wins; reset lands mid-tenure.
        step("pre_rst_a", 8'h10, 8'h10, 8'h10, 3'd4, 1'b0, 1'b0);
        step("pre_rst_b", 8'h10, 8'h10, 8'h10, 3'd4, 1'b1, 1'b1);
        #5;
        rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'h00);
        chk("arst_sel", 32'(sel), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_out", 32'(out), 32'h0);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        #1;
        rst = 1'b0;

        // All requesting after reset: walk from requester 0, four cycles each.
        for (int i = 0; i < 36; i++)
            step("walk", 8'hFF, 8'h00, 8'(1 << ((i / 4) % 8)), 3'((i / 4) % 8), 1'b0, i != 0);
        step("walk_drop", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        step("walk_idle", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // Pointer is 1: requester 2 wins, drops early, 3 and 4 skipped for 5.
        step("skip_a", 8'h24, 8'hFB, 8'h04, 3'd2, 1'b0, 1'b0);
        step("skip_b", 8'h24, 8'hFB, 8'h04, 3'd2, 1'b0, 1'b1);
        step("skip_c", 8'h20, 8'hFB, 8'h20, 3'd5, 1'b0, 1'b1);
        step("dp_1", 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1);
        step("dp_0", 8'h20, 8'hDF, 8'h20, 3'd5, 1'b0, 1'b1);
        step("dp_1b", 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1);
        step("dp_1c", 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1);
        step("dp_end", 8'h00, 8'hFF, 8'h00, 3'd5, 1'b1, 1'b1);
        step("dp_idle", 8'h00, 8'hFF, 8'h00, 3'd5, 1'b0, 1'b0);

        // Pointer is 6: owner 7 expires with req=81, wraps to 0, then back to 7.
        step("wrap_a", 8'h80, 8'h00, 8'h80, 3'd7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("wrap_hold7", 8'h81, 8'h00, 8'h80, 3'd7, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            step("wrap_own0", 8'h81, 8'h00, 8'h01, 3'd0, 1'b0, 1'b1);
        step("wrap_back7", 8'h81, 8'h00, 8'h80, 3'd7, 1'b0, 1'b1);
        step("wrap_end", 8'h00, 8'h00, 8'h00, 3'd7, 1'b0, 1'b1);
        step("wrap_idle", 8'h00, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_8x1_rr_arbiter.md
# mux_8x1_rr_arbiter

Round-robin scheduler that shares one 1-bit output channel between 8 requesters. It arbitrates `req[7:0]`, issues a one-hot registered `grant` and a matching 3-bit `sel`, and drives the registered channel output `out` from `in[sel]`. A grant lasts until the owner drops its request or uses up `MAX_BURST` cycles. The block sits in front of the datapath's 8:1 bit-select and sequences which source owns the channel.

## Interface
- `MAX_BURST`, default 4: maximum consecutive grant cycles per tenure. Legal range 1..15; the count register is 4 bits.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 8: per-requester request, level-sensitive.
- `in` input 8: per-requester data bit; `in[k]` belongs to requester k.
- `grant` output 8: one-hot or zero, registered.
- `sel` output 3: index of the current owner, registered. Holds its last value when idle.
- `busy` output 1: high while any grant is active. Equals `|grant`.
- `out` output 1: registered channel data.
- `out_valid` output 1: `busy` delayed by one cycle; qualifies `out`.

## Operation
- Reset: `grant`=0, `sel`=0, `busy`=0, `out`=0, `out_valid`=0. Internal `ptr`=0, `count`=0, state=IDLE.
- State machine has two states, IDLE and GRANT.
- Arbitration function: the winner is the first k in order ptr, ptr+1, …, ptr+7 (mod 8) with `req[k]`=1.
- IDLE, on any edge with `req`≠0:
  - grant winner; `sel`←winner; `count`←1; go to GRANT.
- IDLE with `req`=0: stay in IDLE; outputs hold their idle values.
- GRANT, release condition: `req[sel]`=0, or `count`=`MAX_BURST`.
- GRANT, on release:
  - `ptr`←`sel`+1 (mod 8, 3-bit wrap 7→0).
  - Re-arbitrate over the current `req` using the new `ptr`.
  - If there is a winner: grant it in the same edge and set `count`←1. There is no idle bubble.
  - If the current owner still requests and is the only requester, it wins again and `grant` stays high.
  - If `req`=0: `grant`←0, `busy`←0, go to IDLE. `sel` holds.
- GRANT, no release: `count`←`count`+1. `grant` and `sel` are unchanged.
- Data path, every edge:
  - `out`←`busy` ? `in[sel]` : 0, using the pre-edge `sel` and `busy`.
  - `out_valid`←`busy`.
- `grant` is never more than one-hot. `sel` always equals the index of the set `grant` bit when `busy`=1.
- Requests are not latched. A requester that raises and drops `req` between edges is never seen.

## Timing
- Grant latency is 1 cycle: `req[k]` high before edge n in IDLE gives `grant[k]`=1 after edge n.
- Tenure with `req` held: exactly `MAX_BURST` cycles of `grant`.
- Early drop: if `req[sel]` falls before edge m, `grant` falls (or moves to another requester) at edge m.
- Handover between requesters takes zero cycles; `grant` changes one-hot in a single edge.
- `out` lags `grant` by one cycle. `in[sel]` sampled at edge m appears on `out` after edge m+1's… no: it appears after edge m and is qualified by `out_valid`.
- Simultaneous drop of all requests plus burst expiry on the same edge: go to IDLE.
- Reset mid-tenure: all outputs go to their reset values immediately (asynchronously). `ptr` returns to 0. The first grant after reset release again scans from requester 0.

## Test plan
- Reset: assert `rst` mid-tenure while `grant`=8'h10 → `grant`=0, `busy`=0, `out`=0, `out_valid`=0 with no clock edge. After release with `req`=8'hFF → first `grant`=8'h01.
- Single holder, `MAX_BURST`=4: `req`=8'h08 held for 12 cycles → `grant`=8'h08 continuously, `sel`=3, and `count` restarts every 4 cycles. After `req` drops → `grant`=0 one edge later.
- All requesting: `req`=8'hFF held → `grant` walks 8'h01, 8'h02, …, 8'h80, each for 4 cycles, then wraps to 8'h01. No gap cycles.
- Early release and skip: `req`=8'h24, and requester 2 drops after 2 cycles → `grant` 8'h04 for 2 cycles, then 8'h20. Requesters 3 and 4 are skipped.
- Pointer wrap: owner 7 releases while `req`=8'h81 → next `grant`=8'h01, then 8'h80.
- Data path: owner 5 with `in[5]` toggling 1,0,1,1 and the other `in` bits held at the opposite value → `out` shows 1,0,1,1, one cycle later, with `out_valid`=1. After the tenure ends and the block goes idle → `out`=0, `out_valid`=0.
